// File: rtl/seq_pattern_tx_if.sv
// Bus between a serial pattern transmitter and its controller.
// Optional abort line present when SEQ_TX_ABORT_EN is defined.
interface seq_pattern_tx_if #(
    parameter int PAT_W = 5,
    parameter int CNT_W = 8
);
    logic             start;
    logic             pat_ld;
    logic [PAT_W-1:0] pat_in;
    logic [CNT_W-1:0] rpt;
    logic             data;
    logic             data_vld;
    logic             busy;
    logic             done;
`ifdef SEQ_TX_ABORT_EN
    logic             abort;

    modport master (output start, pat_ld, pat_in, rpt, abort,
                    input  data, data_vld, busy, done);
    modport slave  (input  start, pat_ld, pat_in, rpt, abort,
                    output data, data_vld, busy, done);
`else
    modport master (output start, pat_ld, pat_in, rpt,
                    input  data, data_vld, busy, done);
    modport slave  (input  start, pat_ld, pat_in, rpt,
                    output data, data_vld, busy, done);
`endif
endinterface

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: sends a PAT_W-bit pattern MSB-first, repeated rpt times
// with GAP_CYC idle zeros between repeats. Define SEQ_TX_ABORT_EN to add the abort input.
module seq_pattern_tx #(
    parameter int               PAT_W   = 5,
    parameter logic [PAT_W-1:0] PATTERN = 5'b10111,
    parameter int               GAP_CYC = 2,
    parameter int               CNT_W   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    seq_pattern_tx_if.slave tx_if
);
    localparam int BIT_W = $clog2(PAT_W);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] RPT_ONE  = CNT_W'(1);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        SHIFT = 4'b0010,
        GAP   = 4'b0100,
        DONE  = 4'b1000
    } state_e;

    state_e           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [BIT_W-1:0] bit_q;
    logic [CNT_W-1:0] rpt_q;
    logic [GAP_W-1:0] gap_q;
    logic             data_q;
    logic             vld_q;
    logic             busy_q;
    logic             done_q;

    logic [PAT_W-1:0] pat_d;
    logic [CNT_W-1:0] rpt_d;
    logic             abort_s;

    // A load in the same cycle as start takes effect for that transmission.
    assign pat_d = tx_if.pat_ld ? tx_if.pat_in : pat_q;
    assign rpt_d = (tx_if.rpt == {CNT_W{1'b0}}) ? RPT_ONE : tx_if.rpt;

`ifdef SEQ_TX_ABORT_EN
    assign abort_s = tx_if.abort;
`else
    assign abort_s = 1'b0;
`endif

    // Transmit FSM with all counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q   <= PATTERN;
            bit_q   <= {BIT_W{1'b0}};
            rpt_q   <= {CNT_W{1'b0}};
            gap_q   <= {GAP_W{1'b0}};
            data_q  <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (abort_s && busy_q) begin
            state_q <= IDLE;
            bit_q   <= {BIT_W{1'b0}};
            rpt_q   <= {CNT_W{1'b0}};
            gap_q   <= {GAP_W{1'b0}};
            data_q  <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    pat_q  <= pat_d;
                    done_q <= 1'b0;
                    if (tx_if.start) begin
                        state_q <= SHIFT;
                        rpt_q   <= rpt_d;
                        bit_q   <= BIT_MSB;
                        data_q  <= pat_d[PAT_W-1];
                        vld_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end else begin
                        data_q  <= 1'b0;
                        vld_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (bit_q != {BIT_W{1'b0}}) begin
                        bit_q  <= bit_q - BIT_W'(1);
                        data_q <= pat_q[bit_q - BIT_W'(1)];
                        vld_q  <= 1'b1;
                    end else if (rpt_q > RPT_ONE) begin
                        rpt_q <= rpt_q - RPT_ONE;
                        if (GAP_CYC > 0) begin
                            state_q <= GAP;
                            gap_q   <= {GAP_W{1'b0}};
                            data_q  <= 1'b0;
                            vld_q   <= 1'b0;
                        end else begin
                            bit_q  <= BIT_MSB;
                            data_q <= pat_q[PAT_W-1];
                            vld_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= DONE;
                        data_q  <= 1'b0;
                        vld_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= SHIFT;
                        bit_q   <= BIT_MSB;
                        data_q  <= pat_q[PAT_W-1];
                        vld_q   <= 1'b1;
                    end else begin
                        gap_q   <= gap_q + GAP_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    data_q  <= 1'b0;
                    vld_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    data_q  <= 1'b0;
                    vld_q   <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_if.data     = data_q;
    assign tx_if.data_vld = vld_q;
    assign tx_if.busy     = busy_q;
    assign tx_if.done     = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx (PAT_W=5, PATTERN=10111, GAP_CYC=2).
// Per-cycle vectors are {data, data_vld, busy, done}, written MSB = first cycle.
module tb_seq_pattern_tx;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    seq_pattern_tx_if #(.PAT_W(5), .CNT_W(8)) tx_if ();

    seq_pattern_tx #(
        .PAT_W(5), .PATTERN(5'b10111), .GAP_CYC(2), .CNT_W(8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tx_if (tx_if)
    );

    always #5 clk = ~clk;

`ifdef SEQ_TX_ABORT_EN
    // Reference detector on the serial line: counts completed 10111 sequences.
    logic [3:0] win = 4'b0000;
    int         det = 0;
    always @(posedge clk) begin
        if (tx_if.data_vld && {win, tx_if.data} == 5'b10111) det++;
        win = {win[2:0], tx_if.data};
    end
`endif

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [3:0] obs();
        return {tx_if.data, tx_if.data_vld, tx_if.busy, tx_if.done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Compares n cycles, then after each compare drives start/pat_ld from the masks.
    task automatic check_seq(input string tag, input int n,
                             input logic [31:0] d, input logic [31:0] v,
                             input logic [31:0] b, input logic [31:0] dn,
                             input logic [31:0] st, input logic [31:0] ld,
                             input logic [4:0] ld_val);
        for (int i = 0; i < n; i++) begin
            logic [3:0] e;
            e = {d[n-1-i], v[n-1-i], b[n-1-i], dn[n-1-i]};
            check_eq($sformatf("%s[%0d]", tag, i), {28'd0, obs()}, {28'd0, e});
            tx_if.start  = st[n-1-i];
            tx_if.pat_ld = ld[n-1-i];
            tx_if.pat_in = ld[n-1-i] ? ld_val : 5'b00000;
            step();
        end
    endtask

    task automatic kick();
        tx_if.start = 1'b1;
        step();
        tx_if.start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef SEQ_TX_ABORT_EN
        int det0;
`endif
        rst_n        = 1'b0;
        tx_if.start  = 1'b0;
        tx_if.pat_ld = 1'b0;
        tx_if.pat_in = 5'b00000;
        tx_if.rpt    = 8'd1;
`ifdef SEQ_TX_ABORT_EN
        tx_if.abort  = 1'b0;
`endif
        #1;
        check_eq("rst_in", {28'd0, obs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("rst_idle", {28'd0, obs()}, 32'd0);

        // Single frame of the reset pattern.
        kick();
        check_seq("t1", 7, 7'b1011100, 7'b1111100, 7'b1111100, 7'b0000010, 0, 0, 5'b00000);

        // Two repeats with a two-cycle gap.
        tx_if.rpt = 8'd2;
        kick();
        check_seq("t2", 14, 14'b10111001011100, 14'b11111001111100,
                  14'b11111111111100, 14'b00000000000010, 0, 0, 5'b00000);

        // Load a new pattern in IDLE, then rpt=0 sends it once.
        tx_if.pat_ld = 1'b1;
        tx_if.pat_in = 5'b11001;
        step();
        tx_if.pat_ld = 1'b0;
        tx_if.pat_in = 5'b00000;
        tx_if.rpt    = 8'd0;
        check_eq("t3_idle", {28'd0, obs()}, 32'd0);
        kick();
        check_seq("t3", 7, 7'b1100100, 7'b1111100, 7'b1111100, 7'b0000010, 0, 0, 5'b00000);

        // Mid-frame start+load ignored, start in DONE ignored, start in IDLE accepted.
        tx_if.rpt = 8'd1;
        kick();
        check_seq("t4", 8, 8'b11001001, 8'b11111001, 8'b11111001, 8'b00000100,
                  8'b01000110, 8'b01000000, 5'b00110);
        check_seq("t4b", 6, 6'b100100, 6'b111100, 6'b111100, 6'b000010, 0, 0, 5'b00000);

        // Asynchronous reset mid-frame restores the default pattern.
        kick();
        check_seq("t5", 3, 3'b110, 3'b111, 3'b111, 3'b000, 0, 0, 5'b00000);
        rst_n = 1'b0;
        #1;
        check_eq("t5_rst", {28'd0, obs()}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check_eq("t5_idle", {28'd0, obs()}, 32'd0);
        kick();
        check_seq("t5_pat", 7, 7'b1011100, 7'b1111100, 7'b1111100, 7'b0000010, 0, 0, 5'b00000);

`ifdef SEQ_TX_ABORT_EN
        // Abort at bit 2: straight to IDLE with no done and no detection.
        kick();
        check_seq("t6", 2, 2'b10, 2'b11, 2'b11, 2'b00, 0, 0, 5'b00000);
        det0 = det;
        tx_if.abort = 1'b1;
        check_seq("t6_ab", 1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 5'b00000);
        tx_if.abort = 1'b0;
        check_seq("t6_idle", 3, 3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 5'b00000);
        check_eq("t6_nodet", det, det0);
        // Abort together with start in IDLE: start wins, full frame detected.
        det0 = det;
        tx_if.abort = 1'b1;
        tx_if.start = 1'b1;
        step();
        tx_if.abort = 1'b0;
        tx_if.start = 1'b0;
        check_seq("t6_sw", 7, 7'b1011100, 7'b1111100, 7'b1111100, 7'b0000010, 0, 0, 5'b00000);
        check_eq("t6_det", det, det0 + 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
